// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver for the debug UART link (LSB first, idle-high).
// The line is synchronized, then sampled at mid-bit by a down-counting bit timer
// that restarts on every start edge. Each byte whose stop bit is high is
// presented on DATA_O together with a one-cycle RX_DONE_O strobe. A low stop bit
// gives a one-cycle FRAME_ERR_O strobe.
// Optional feature macro: UART_RX_ESC_FILTER_EN. When it is defined, ESC bytes
// enter pause, RESUME bytes leave it, and both are swallowed. ESC received while
// already paused is also swallowed. PAUSED_O shows the pause level.
// STATE_O exposes the FSM state for debug and checker binding.
// Handshake: RX_DONE_O and FRAME_ERR_O are single-cycle strobes with no back-pressure.
// DATA_O is valid in the cycle RX_DONE_O is high and is held until the next RX_DONE_O.
module uart_rx #(
   parameter int          CLK_RATE  = 100*10**6,
   parameter int          BAUD_RATE = 115200,
   parameter logic [7:0]  ESC       = 8'hB1,
   parameter logic [7:0]  RESUME    = 8'h00
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       RX_I,
   output logic [7:0] DATA_O,
   output logic       RX_DONE_O,
   output logic       FRAME_ERR_O,
   output logic       RX_BUSY_O,
   output logic       PAUSED_O,
   output logic [2:0] STATE_O
);

   // BIT_CYCLES must be at least 4 so the half-bit reload is non-zero.
   localparam int BIT_CYCLES = CLK_RATE / BAUD_RATE;
   localparam int CNT_W      = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYCLES / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_HIGH = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             rx_meta, rx_s;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic [7:0]       data_q;
   logic             done_q, ferr_q;
   logic             sample;
   logic             stop_ok, stop_bad, deliver;
`ifdef UART_RX_ESC_FILTER_EN
   logic             paused_q;
   logic             pause_set, pause_clr;
`endif

   // A sample point is the bit timer reaching zero while a frame is in progress.
   assign sample = (state_q != S_IDLE) && (cnt_q == '0);

   // Two-flop synchronizer. It resets to the idle-high line level.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX_I;
         rx_s    <= rx_meta;
      end
   end

   // FSM state register.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state logic. IDLE is re-entered at mid stop bit, so a start bit
   // that follows with no gap is still detected.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (!rx_s) state_d = S_START;
         S_START:     if (sample) state_d = rx_s ? S_IDLE : S_DATA;
         S_DATA:      if (sample && (bit_idx_q == 3'd7)) state_d = S_STOP;
         S_STOP:      if (sample) state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
         S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // FSM outputs and stop-bit decisions, including the pause filter.
   always_comb begin
      RX_BUSY_O = (state_q != S_IDLE);
      stop_ok   = (state_q == S_STOP) && sample && rx_s;
      stop_bad  = (state_q == S_STOP) && sample && !rx_s;
`ifdef UART_RX_ESC_FILTER_EN
      pause_set = stop_ok && !paused_q && (shift_q == ESC);
      pause_clr = stop_ok && paused_q && (shift_q == RESUME);
      deliver   = stop_ok && !pause_set && !pause_clr
                  && !(paused_q && (shift_q == ESC));
`else
      deliver   = stop_ok;
`endif
   end

   // Bit timer, bit index and shift register.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
      end else begin
         if (state_q == S_IDLE) begin
            if (!rx_s) cnt_q <= CNT_HALF;
         end else if (sample) begin
            cnt_q <= CNT_FULL;
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
         if ((state_q == S_START) && sample && !rx_s) bit_idx_q <= 3'd0;
         if ((state_q == S_DATA) && sample) begin
            shift_q[bit_idx_q] <= rx_s;
            bit_idx_q          <= bit_idx_q + 3'd1;
         end
      end
   end

   // Registered result: strobes last one cycle, and DATA_O changes only on delivery.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         data_q <= 8'h00;
         done_q <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         done_q <= deliver;
         ferr_q <= stop_bad;
         if (deliver) data_q <= shift_q;
      end
   end

`ifdef UART_RX_ESC_FILTER_EN
   // Pause level is driven by valid-stop ESC and RESUME bytes only.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I)          paused_q <= 1'b0;
      else if (pause_set) paused_q <= 1'b1;
      else if (pause_clr) paused_q <= 1'b0;
   end
   assign PAUSED_O = paused_q;
`else
   assign PAUSED_O = 1'b0;
`endif

   assign DATA_O      = data_q;
   assign RX_DONE_O   = done_q;
   assign FRAME_ERR_O = ferr_q;
   assign STATE_O     = state_q;

endmodule
